// File: rtl/fm_wb_packer.sv
// Write-back packer: packs the 8-bit feature-map stream and the 6-bit guard stream into SRAM words.
// Each lane auto-increments its address, and a partial final word is flushed zero-padded at job end.
module fm_wb_packer #(
    parameter int unsigned FM_BYTES_PER_WORD = 8,
    parameter int unsigned GUARD_PER_WORD    = 4,
    parameter int unsigned FM_ADDR_WIDTH     = 12,
    parameter int unsigned GUARD_ADDR_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start,
    input  logic [FM_ADDR_WIDTH-1:0]      cfg_fm_base,
    input  logic [GUARD_ADDR_WIDTH-1:0]   cfg_guard_base,
    input  logic [15:0]                   cfg_fm_len,
    input  logic [15:0]                   cfg_guard_len,
    input  logic [7:0]                    data_i,
    input  logic                          data_valid_i,
    output logic                          data_ready_o,
    input  logic [5:0]                    guard_i,
    input  logic                          guard_valid_i,
    output logic                          guard_ready_o,
    output logic                          fm_wr_en,
    output logic [FM_ADDR_WIDTH-1:0]      fm_wr_addr,
    output logic [8*FM_BYTES_PER_WORD-1:0] fm_wr_data,
    output logic                          guard_wr_en,
    output logic [GUARD_ADDR_WIDTH-1:0]   guard_wr_addr,
    output logic [6*GUARD_PER_WORD-1:0]   guard_wr_data,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned FM_DATA_W = 8 * FM_BYTES_PER_WORD;
    localparam int unsigned G_DATA_W  = 6 * GUARD_PER_WORD;
    localparam int unsigned FM_SLOT_W = $clog2(FM_BYTES_PER_WORD);
    localparam int unsigned G_SLOT_W  = $clog2(GUARD_PER_WORD);
    localparam logic [FM_SLOT_W-1:0] FM_LAST_SLOT = FM_SLOT_W'(FM_BYTES_PER_WORD - 1);
    localparam logic [G_SLOT_W-1:0]  G_LAST_SLOT  = G_SLOT_W'(GUARD_PER_WORD - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                      state_q;
    logic [15:0]                 fm_len_q, guard_len_q;
    logic [15:0]                 fm_cnt_q, guard_cnt_q;
    logic [FM_ADDR_WIDTH-1:0]    fm_addr_q;
    logic [GUARD_ADDR_WIDTH-1:0] guard_addr_q;
    logic [FM_SLOT_W-1:0]        fm_slot_q;
    logic [G_SLOT_W-1:0]         guard_slot_q;
    logic [FM_DATA_W-1:0]        fm_pack_q, fm_word;
    logic [G_DATA_W-1:0]         guard_pack_q, guard_word;

    logic fm_full, guard_full, start_now, flush_now, fm_accept, guard_accept;

    assign fm_full       = (fm_cnt_q == fm_len_q);
    assign guard_full    = (guard_cnt_q == guard_len_q);
    assign start_now     = (state_q == StIdle) && cfg_start;
    assign flush_now     = (state_q == StRun) && fm_full && guard_full;
    assign data_ready_o  = (state_q == StRun) && (fm_cnt_q < fm_len_q);
    assign guard_ready_o = (state_q == StRun) && (guard_cnt_q < guard_len_q);
    assign fm_accept     = data_valid_i && data_ready_o;
    assign guard_accept  = guard_valid_i && guard_ready_o;

    // Packing register with the incoming element dropped into its slot.
    always_comb begin
        fm_word = fm_pack_q;
        fm_word[fm_slot_q*8 +: 8] = data_i;
        guard_word = guard_pack_q;
        guard_word[guard_slot_q*6 +: 6] = guard_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            fm_len_q    <= '0;
            guard_len_q <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        state_q     <= StRun;
                        busy        <= 1'b1;
                        fm_len_q    <= cfg_fm_len;
                        guard_len_q <= cfg_guard_len;
                    end
                end
                StRun: begin
                    if (fm_full && guard_full) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fm_cnt_q   <= '0;
            fm_addr_q  <= '0;
            fm_slot_q  <= '0;
            fm_pack_q  <= '0;
            fm_wr_en   <= 1'b0;
            fm_wr_addr <= '0;
            fm_wr_data <= '0;
        end else begin
            fm_wr_en <= 1'b0;
            if (start_now) begin
                fm_cnt_q  <= '0;
                fm_addr_q <= cfg_fm_base;
                fm_slot_q <= '0;
                fm_pack_q <= '0;
            end else if (fm_accept) begin
                fm_cnt_q <= fm_cnt_q + 16'd1;
                if (fm_slot_q == FM_LAST_SLOT) begin
                    fm_wr_en   <= 1'b1;
                    fm_wr_addr <= fm_addr_q;
                    fm_wr_data <= fm_word;
                    fm_addr_q  <= fm_addr_q + FM_ADDR_WIDTH'(1);
                    fm_slot_q  <= '0;
                    fm_pack_q  <= '0;
                end else begin
                    fm_slot_q <= fm_slot_q + FM_SLOT_W'(1);
                    fm_pack_q <= fm_word;
                end
            end else if (flush_now && (fm_slot_q != '0)) begin
                // Unused upper slots are already zero since the register clears after each write.
                fm_wr_en   <= 1'b1;
                fm_wr_addr <= fm_addr_q;
                fm_wr_data <= fm_pack_q;
                fm_addr_q  <= fm_addr_q + FM_ADDR_WIDTH'(1);
                fm_slot_q  <= '0;
                fm_pack_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_cnt_q   <= '0;
            guard_addr_q  <= '0;
            guard_slot_q  <= '0;
            guard_pack_q  <= '0;
            guard_wr_en   <= 1'b0;
            guard_wr_addr <= '0;
            guard_wr_data <= '0;
        end else begin
            guard_wr_en <= 1'b0;
            if (start_now) begin
                guard_cnt_q  <= '0;
                guard_addr_q <= cfg_guard_base;
                guard_slot_q <= '0;
                guard_pack_q <= '0;
            end else if (guard_accept) begin
                guard_cnt_q <= guard_cnt_q + 16'd1;
                if (guard_slot_q == G_LAST_SLOT) begin
                    guard_wr_en   <= 1'b1;
                    guard_wr_addr <= guard_addr_q;
                    guard_wr_data <= guard_word;
                    guard_addr_q  <= guard_addr_q + GUARD_ADDR_WIDTH'(1);
                    guard_slot_q  <= '0;
                    guard_pack_q  <= '0;
                end else begin
                    guard_slot_q <= guard_slot_q + G_SLOT_W'(1);
                    guard_pack_q <= guard_word;
                end
            end else if (flush_now && (guard_slot_q != '0)) begin
                guard_wr_en   <= 1'b1;
                guard_wr_addr <= guard_addr_q;
                guard_wr_data <= guard_pack_q;
                guard_addr_q  <= guard_addr_q + GUARD_ADDR_WIDTH'(1);
                guard_slot_q  <= '0;
                guard_pack_q  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fm_wb_packer.sv
// Directed bench for fm_wb_packer: expected SRAM writes are queued as stimulus is accepted and
// popped by a negedge monitor when the DUT writes.
module tb_fm_wb_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [11:0] cfg_fm_base = '0;
    logic [9:0]  cfg_guard_base = '0;
    logic [15:0] cfg_fm_len = '0;
    logic [15:0] cfg_guard_len = '0;
    logic [7:0]  data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [5:0]  guard_i = '0;
    logic        guard_valid_i = 1'b0;
    logic        guard_ready_o;
    logic        fm_wr_en;
    logic [11:0] fm_wr_addr;
    logic [63:0] fm_wr_data;
    logic        guard_wr_en;
    logic [9:0]  guard_wr_addr;
    logic [23:0] guard_wr_data;
    logic        busy;
    logic        done;

    fm_wb_packer dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_fm_base    (cfg_fm_base),
        .cfg_guard_base (cfg_guard_base),
        .cfg_fm_len     (cfg_fm_len),
        .cfg_guard_len  (cfg_guard_len),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .data_ready_o   (data_ready_o),
        .guard_i        (guard_i),
        .guard_valid_i  (guard_valid_i),
        .guard_ready_o  (guard_ready_o),
        .fm_wr_en       (fm_wr_en),
        .fm_wr_addr     (fm_wr_addr),
        .fm_wr_data     (fm_wr_data),
        .guard_wr_en    (guard_wr_en),
        .guard_wr_addr  (guard_wr_addr),
        .guard_wr_data  (guard_wr_data),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        int          cyc;   // 0 = timing not checked
    } exp_t;

    exp_t fm_q[$];
    exp_t g_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fm_wr_en) begin
                check("fm_write_expected", 64'(fm_q.size() != 0), 64'd1);
                if (fm_q.size() != 0) begin
                    e = fm_q.pop_front();
                    check("fm_addr", 64'(fm_wr_addr), 64'(e.addr));
                    check("fm_data", fm_wr_data, e.data);
                    if (e.cyc != 0) check("fm_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            if (guard_wr_en) begin
                check("guard_write_expected", 64'(g_q.size() != 0), 64'd1);
                if (g_q.size() != 0) begin
                    e = g_q.pop_front();
                    check("guard_addr", 64'(guard_wr_addr), 64'(e.addr));
                    check("guard_data", 64'(guard_wr_data), e.data);
                    if (e.cyc != 0) check("guard_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic drive_fm(input int n, input logic [7:0] first, input logic [11:0] base,
                            input bit gaps, input bit flush);
        logic [63:0] word = '0;
        logic [11:0] addr = base;
        int slot = 0;
        int i = 0;
        int waited = 0;
        while (i < n) begin
            @(negedge clk);
            data_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            data_i = 8'(first + i);
            if (data_valid_i && data_ready_o) begin
                word[slot*8 +: 8] = data_i;
                slot++;
                i++;
                waited = 0;
                if (slot == 8) begin
                    fm_q.push_back('{addr: 16'(addr), data: word, cyc: cyc + 1});
                    addr = addr + 12'd1;
                    slot = 0;
                    word = '0;
                end
            end else begin
                waited++;
                if (waited > 50) begin
                    check("fm_accept_timeout", 64'(waited), 64'd0);
                    break;
                end
            end
        end
        if (flush && slot != 0) fm_q.push_back('{addr: 16'(addr), data: word, cyc: 0});
        @(negedge clk);
        data_valid_i = 1'b0;
    endtask

    task automatic drive_guard(input int n, input logic [5:0] first, input logic [9:0] base,
                               input bit gaps);
        logic [63:0] word = '0;
        logic [9:0]  addr = base;
        int slot = 0;
        int i = 0;
        int waited = 0;
        while (i < n) begin
            @(negedge clk);
            guard_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            guard_i = 6'(first + i);
            if (guard_valid_i && guard_ready_o) begin
                word[slot*6 +: 6] = guard_i;
                slot++;
                i++;
                waited = 0;
                if (slot == 4) begin
                    g_q.push_back('{addr: 16'(addr), data: word, cyc: cyc + 1});
                    addr = addr + 10'd1;
                    slot = 0;
                    word = '0;
                end
            end else begin
                waited++;
                if (waited > 50) begin
                    check("guard_accept_timeout", 64'(waited), 64'd0);
                    break;
                end
            end
        end
        if (slot != 0) g_q.push_back('{addr: 16'(addr), data: word, cyc: 0});
        @(negedge clk);
        guard_valid_i = 1'b0;
    endtask

    task automatic run_job(input logic [11:0] fb, input logic [9:0] gb, input int fl, input int gl,
                           input logic [7:0] ff, input logic [5:0] gf, input bit gaps);
        int d0 = done_cnt;
        int t = 0;
        @(negedge clk);
        cfg_fm_base = fb;
        cfg_guard_base = gb;
        cfg_fm_len = 16'(fl);
        cfg_guard_len = 16'(gl);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("busy_in_job", 64'(busy), 64'd1);
        fork
            drive_fm(fl, ff, fb, gaps, 1'b1);
            drive_guard(gl, gf, gb, gaps);
        join
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("fm_writes_missing", 64'(fm_q.size()), 64'd0);
        check("guard_writes_missing", 64'(g_q.size()), 64'd0);
    endtask

    initial begin
        int s;
        int d0;
        repeat (3) @(negedge clk);
        check("rst_fm_wr_en", 64'(fm_wr_en), 64'd0);
        check("rst_fm_wr_data", fm_wr_data, 64'd0);
        check("rst_guard_wr_en", 64'(guard_wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data_ready", 64'(data_ready_o), 64'd0);
        rst = 1'b0;

        run_job(12'h010, 10'h000, 16, 0, 8'h00, 6'd0, 1'b0);
        check("job1_last_addr", 64'(fm_wr_addr), 64'h011);
        check("job1_last_data", fm_wr_data, 64'h0F0E0D0C0B0A0908);

        run_job(12'h020, 10'h000, 10, 0, 8'hA0, 6'd0, 1'b0);
        check("flush_addr", 64'(fm_wr_addr), 64'h021);
        check("flush_data", fm_wr_data, 64'h000000000000A9A8);

        run_job(12'h030, 10'h005, 20, 6, 8'h40, 6'd1, 1'b1);
        check("guard_flush_addr", 64'(guard_wr_addr), 64'h006);
        check("guard_flush_data", 64'(guard_wr_data), 64'h000185);

        run_job(12'hFFF, 10'h000, 16, 0, 8'h10, 6'd0, 1'b0);
        check("wrap_addr", 64'(fm_wr_addr), 64'h000);

        // Both lanes fill their last slot on the same cycle.
        run_job(12'h200, 10'h100, 8, 4, 8'h55, 6'd9, 1'b0);

        // Empty job, with cfg_start held high while busy.
        d0 = done_cnt;
        @(negedge clk);
        cfg_fm_len = 16'd0;
        cfg_guard_len = 16'd0;
        cfg_start = 1'b1;
        s = cyc;
        repeat (3) @(negedge clk);
        cfg_start = 1'b0;
        repeat (6) @(negedge clk);
        check("empty_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("empty_done_latency", 64'(done_cyc - s), 64'd3);
        check("empty_busy_after", 64'(busy), 64'd0);

        // Reset in the middle of a job.
        @(negedge clk);
        cfg_fm_base = 12'h100;
        cfg_guard_base = 10'h000;
        cfg_fm_len = 16'd16;
        cfg_guard_len = 16'd0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        drive_fm(5, 8'h30, 12'h100, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_fm_wr_data", fm_wr_data, 64'd0);
        check("midrst_fm_wr_addr", 64'(fm_wr_addr), 64'd0);
        check("midrst_guard_wr_data", 64'(guard_wr_data), 64'd0);
        check("midrst_data_ready", 64'(data_ready_o), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_job(12'h040, 10'h000, 10, 0, 8'hA0, 6'd0, 1'b0);
        check("post_rst_flush_addr", 64'(fm_wr_addr), 64'h041);
        check("post_rst_flush_data", fm_wr_data, 64'h000000000000A9A8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
